// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared port ids, read latency, mask encodings and read-slot type.
package mem_arbiter_pkg;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;
    localparam int MEM_RD_LATENCY = 2;
    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_LO = 2'b01;
    localparam logic [1:0] MASK_HI = 2'b10;
    localparam logic [1:0] MASK_WORD = 2'b11;
    typedef struct packed {
        logic valid;
        logic port;
    } rd_slot_t;
endpackage

// File: rtl/mem_arb_rd_pipe.sv
// mem_arb_rd_pipe: {valid, port} shift register matching memory read latency; drives both RVALIDs.
module mem_arb_rd_pipe
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  rd_slot_t in_slot,
    output logic     rvalid0,
    output logic     rvalid1
);
    rd_slot_t [MEM_RD_LATENCY-1:0] stage;
    always_ff @(posedge clk) begin
        if (rst) stage <= '0;
        else stage <= {stage[MEM_RD_LATENCY-2:0], in_slot};
    end
    assign rvalid0 = stage[MEM_RD_LATENCY-1].valid && stage[MEM_RD_LATENCY-1].port == PORT_CPU;
    assign rvalid1 = stage[MEM_RD_LATENCY-1].valid && stage[MEM_RD_LATENCY-1].port == PORT_DMA;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port SPRAM, fixed-latency read return.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of port 0 priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BITS = 16,
    parameter int ADDRESS_BITS = 15
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    M0_REQ,
    input  logic                    M0_WR,
    input  logic [ADDRESS_BITS-1:0] M0_ADDR,
    input  logic [BITS-1:0]         M0_WDATA,
    input  logic [1:0]              M0_MASK,
    output logic                    M0_ACK,
    output logic [BITS-1:0]         M0_RDATA,
    output logic                    M0_RVALID,
    input  logic                    M1_REQ,
    input  logic                    M1_WR,
    input  logic [ADDRESS_BITS-1:0] M1_ADDR,
    input  logic [BITS-1:0]         M1_WDATA,
    input  logic [1:0]              M1_MASK,
    output logic                    M1_ACK,
    output logic [BITS-1:0]         M1_RDATA,
    output logic                    M1_RVALID,
    output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
    output logic [BITS-1:0]         MEM_DATA_IN,
    output logic [1:0]              MEM_MASK,
    output logic                    MEM_WR,
    input  logic [BITS-1:0]         MEM_DATA_OUT
);
    logic sel;
    logic grant;
    logic wr_sel;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last;
    always_ff @(posedge CLK) begin
        if (RST) last <= PORT_DMA;
        else if (grant) last <= sel;
    end
    assign sel = M1_REQ && (!M0_REQ || last == PORT_CPU);
`else
    assign sel = M1_REQ && !M0_REQ;
`endif
    assign grant = !RST && (M0_REQ || M1_REQ);
    assign M0_ACK = grant && sel == PORT_CPU;
    assign M1_ACK = grant && sel == PORT_DMA;
    assign wr_sel = sel ? M1_WR : M0_WR;
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_ADDRESS <= '0;
            MEM_DATA_IN <= '0;
            MEM_MASK <= MASK_NONE;
            MEM_WR <= 1'b0;
        end else if (grant) begin
            MEM_ADDRESS <= sel ? M1_ADDR : M0_ADDR;
            MEM_DATA_IN <= sel ? M1_WDATA : M0_WDATA;
            MEM_MASK <= wr_sel ? (sel ? M1_MASK : M0_MASK) : MASK_NONE;
            MEM_WR <= wr_sel;
        end else begin
            MEM_WR <= 1'b0;
        end
    end
    mem_arb_rd_pipe u_rd_pipe (
        .clk     (CLK),
        .rst     (RST),
        .in_slot ('{valid: grant && !wr_sel, port: sel}),
        .rvalid0 (M0_RVALID),
        .rvalid1 (M1_RVALID)
    );
    assign M0_RDATA = MEM_DATA_OUT;
    assign M1_RDATA = MEM_DATA_OUT;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic checked against an ideal-memory scoreboard.
module tb_mem_arbiter;
    localparam int BITS = 16;
    localparam int AW = 15;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {
        logic req;
        logic wr;
        logic [AW-1:0] addr;
        logic [BITS-1:0] wdata;
        logic [1:0] mask;
    } txn_t;
    typedef struct {
        int due;
        int port;
        logic [BITS-1:0] data;
    } rd_t;

    logic CLK = 0, RST = 1;
    logic M0_REQ = 0, M0_WR = 0, M1_REQ = 0, M1_WR = 0;
    logic [AW-1:0] M0_ADDR = '0, M1_ADDR = '0;
    logic [BITS-1:0] M0_WDATA = '0, M1_WDATA = '0;
    logic [1:0] M0_MASK = '0, M1_MASK = '0;
    logic M0_ACK, M1_ACK, M0_RVALID, M1_RVALID, MEM_WR;
    logic [BITS-1:0] M0_RDATA, M1_RDATA, MEM_DATA_IN;
    logic [BITS-1:0] MEM_DATA_OUT = '0;
    logic [AW-1:0] MEM_ADDRESS;
    logic [1:0] MEM_MASK;

    int total = 0, bad = 0, cyc = 0, last_g = 1;
    int gcount [2];
    txn_t p [2];
    rd_t sb [$];
    logic [BITS-1:0] ram [0:31];
    logic [BITS-1:0] ref_mem [0:31];
    logic [BITS-1:0] e_data = '0, last_rd0 = '0;
    logic [AW-1:0] e_addr = '0;
    logic [1:0] e_mask = '0;
    logic e_wr = 0;
    logic [BITS-1:0] rd_log [$];
    int rd_cyc [$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.BITS(BITS), .ADDRESS_BITS(AW)) dut (
        .CLK(CLK), .RST(RST),
        .M0_REQ(M0_REQ), .M0_WR(M0_WR), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA), .M0_MASK(M0_MASK),
        .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA), .M0_RVALID(M0_RVALID),
        .M1_REQ(M1_REQ), .M1_WR(M1_WR), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA), .M1_MASK(M1_MASK),
        .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA), .M1_RVALID(M1_RVALID),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA_IN(MEM_DATA_IN), .MEM_MASK(MEM_MASK),
        .MEM_WR(MEM_WR), .MEM_DATA_OUT(MEM_DATA_OUT)
    );

    function automatic logic [BITS-1:0] merge(input logic [BITS-1:0] old, input logic [BITS-1:0] nw,
                                              input logic [1:0] m);
        return {m[1] ? nw[15:8] : old[15:8], m[0] ? nw[7:0] : old[7:0]};
    endfunction

    // SPRAM stand-in: write and read both sampled on the rising edge, data out one cycle later
    always @(posedge CLK) begin
        if (MEM_WR) ram[MEM_ADDRESS[4:0]] <= merge(ram[MEM_ADDRESS[4:0]], MEM_DATA_IN, MEM_MASK);
        MEM_DATA_OUT <= ram[MEM_ADDRESS[4:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r);
        int g;
        logic ev0, ev1;
        logic [BITS-1:0] ed;
        @(negedge CLK);
        RST = r;
        M0_REQ = p[0].req; M0_WR = p[0].wr; M0_ADDR = p[0].addr; M0_WDATA = p[0].wdata; M0_MASK = p[0].mask;
        M1_REQ = p[1].req; M1_WR = p[1].wr; M1_ADDR = p[1].addr; M1_WDATA = p[1].wdata; M1_MASK = p[1].mask;
        #1;
        cyc++;
        ev0 = 0; ev1 = 0; ed = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            ev0 = sb[0].port == 0;
            ev1 = sb[0].port == 1;
            ed = sb[0].data;
            void'(sb.pop_front());
        end
        chk("m0_rvalid", M0_RVALID, ev0);
        chk("m1_rvalid", M1_RVALID, ev1);
        if (ev0) begin
            chk("m0_rdata", M0_RDATA, ed);
            last_rd0 = M0_RDATA;
            rd_log.push_back(M0_RDATA);
            rd_cyc.push_back(cyc);
        end
        if (ev1) chk("m1_rdata", M1_RDATA, ed);
        chk("mem_wr", MEM_WR, e_wr);
        chk("mem_addr", MEM_ADDRESS, e_addr);
        chk("mem_data", MEM_DATA_IN, e_data);
        chk("mem_mask", MEM_MASK, e_mask);
        g = -1;
        if (!r) begin
            if (p[0].req && p[1].req) g = (RR && last_g == 0) ? 1 : 0;
            else if (p[0].req) g = 0;
            else if (p[1].req) g = 1;
        end
        chk("m0_ack", M0_ACK, g == 0);
        chk("m1_ack", M1_ACK, g == 1);
        e_wr = 0;
        if (r) begin
            e_addr = '0; e_data = '0; e_mask = '0;
            sb.delete();
            last_g = 1;
        end else if (g >= 0) begin
            e_addr = p[g].addr;
            e_data = p[g].wdata;
            e_wr = p[g].wr;
            e_mask = p[g].wr ? p[g].mask : 2'b00;
            if (p[g].wr) ref_mem[p[g].addr[4:0]] = merge(ref_mem[p[g].addr[4:0]], p[g].wdata, p[g].mask);
            else sb.push_back('{due: cyc + 2, port: g, data: ref_mem[p[g].addr[4:0]]});
            last_g = g;
            gcount[g]++;
            p[g].req = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    task automatic issue(input int port, input logic wr, input logic [AW-1:0] a,
                         input logic [BITS-1:0] d, input logic [1:0] m);
        p[port] = '{1'b1, wr, a, d, m};
        for (int i = 0; i < 8 && p[port].req; i++) step(0);
        if (p[port].req) begin
            chk("issue_timeout", p[port].req, 0);
            p[port].req = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        p[0] = '{1'b0, 1'b0, '0, '0, 2'b00};
        p[1] = p[0];
        gcount[0] = 0; gcount[1] = 0;
        repeat (2) @(posedge CLK);
        for (int a = 0; a < 32; a++) issue(0, 1, AW'(a), 16'hA000 + 16'(a * 16'h0111), 2'b11);
        idle(2);
        // writes then read of the same word
        last_rd0 = '0;
        issue(0, 1, 15'h0010, 16'hBEEF, 2'b11);
        issue(0, 0, 15'h0010, 16'h0000, 2'b00);
        idle(3);
        chk("t1_rdata", last_rd0, 16'hBEEF);
        // simultaneous reads
        p[0] = '{1'b1, 1'b0, 15'h0001, '0, 2'b00};
        p[1] = '{1'b1, 1'b0, 15'h0002, '0, 2'b00};
        for (int i = 0; i < 6 && (p[0].req || p[1].req); i++) step(0);
        chk("t2_drained", p[0].req || p[1].req, 0);
        idle(3);
        // continuous contention
        gcount[0] = 0; gcount[1] = 0;
        for (int i = 0; i < 8; i++) begin
            if (!p[0].req) p[0] = '{1'b1, 1'b0, 15'h0001, '0, 2'b00};
            if (!p[1].req) p[1] = '{1'b1, 1'b0, 15'h0002, '0, 2'b00};
            step(0);
        end
        chk("t3_port0_grants", gcount[0], RR ? 4 : 8);
        chk("t3_port1_grants", gcount[1], RR ? 4 : 0);
        p[0].req = 0; p[1].req = 0;
        idle(4);
        // back-to-back reads in address order
        rd_log.delete(); rd_cyc.delete();
        for (int a = 0; a < 4; a++) issue(0, 0, AW'(a), '0, 2'b00);
        idle(3);
        chk("t6_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            chk("t6_data", rd_log[i], 16'hA000 + 16'(i * 16'h0111));
            chk("t6_cycle", rd_cyc[i] - rd_cyc[0], i);
        end
        // byte-masked write
        last_rd0 = '0;
        issue(0, 1, 15'h0003, 16'h0055, 2'b11);
        issue(1, 1, 15'h0003, 16'h12AB, 2'b10);
        issue(0, 0, 15'h0003, '0, 2'b00);
        idle(3);
        chk("t4_byte_merge", last_rd0, 16'h1255);
        // reset right after a read is accepted
        issue(0, 0, 15'h0005, 16'h7777, 2'b00);
        step(1);
        step(0);
        chk("t5_mem_wr", MEM_WR, 0);
        chk("t5_mem_addr", MEM_ADDRESS, 0);
        chk("t5_mem_data", MEM_DATA_IN, 0);
        chk("t5_mem_mask", MEM_MASK, 0);
        chk("t5_rvalid", {M0_RVALID, M1_RVALID}, 0);
        idle(4);
        // random traffic with occasional resets while requests are held
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++)
                if (!p[k].req && $urandom_range(2) != 0)
                    p[k] = '{1'b1, 1'($urandom), AW'($urandom_range(7)), 16'($urandom), 2'($urandom)};
            step($urandom_range(39) == 0);
        end
        p[0].req = 0; p[1].req = 0;
        idle(4);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port request/acknowledge arbiter sitting directly upstream of the single-port SPRAM memory wrapper.
- Port 0 is the CPU; port 1 is a DMA/peripheral master.
- Selects one access per clock and registers address, write data, byte mask and write enable toward the memory.
- Tracks outstanding reads so read data is returned to the correct port with a fixed latency.

Parameters:
- BITS, 16, data width of both ports and memory.
- ADDRESS_BITS, 15, word address width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- M0_REQ  in  1  port 0 access request; held until acknowledged.
- M0_WR  in  1  port 0: 1 = write, 0 = read.
- M0_ADDR  in  ADDRESS_BITS  port 0 word address.
- M0_WDATA  in  BITS  port 0 write data.
- M0_MASK  in  2  port 0 byte enables, [1] = high byte, [0] = low byte.
- M0_ACK  out  1  port 0 accepted this cycle (combinational).
- M0_RDATA  out  BITS  port 0 read data.
- M0_RVALID  out  1  M0_RDATA valid this cycle.
- M1_REQ, M1_WR, M1_ADDR, M1_WDATA, M1_MASK, M1_ACK, M1_RDATA, M1_RVALID: same as port 0, for port 1.
- MEM_ADDRESS  out  ADDRESS_BITS  to memory ADDRESS.
- MEM_DATA_IN  out  BITS  to memory DATA_IN.
- MEM_MASK  out  2  to memory MASK.
- MEM_WR  out  1  to memory WR.
- MEM_DATA_OUT  in  BITS  from memory DATA_OUT.

Behaviour:
- Clocking: one clock CLK; reset RST is synchronous and active-high. All state changes occur on the CLK rising edge.
- Reset values: MEM_WR=0, MEM_ADDRESS=0, MEM_DATA_IN=0, MEM_MASK=0, M0_RVALID=0, M1_RVALID=0. Last-grant pointer = port 1, so port 0 wins the first tie. Read pipeline is cleared.
- Grant (combinational):
  - Mx_ACK=1 in the same cycle as Mx_REQ when that port is selected. The transaction is accepted at the following rising edge.
  - The master may change REQ or its fields at that edge.
  - At most one ACK is high per cycle.
  - While RST=1, both ACK outputs are 0.
- Selection:
  - Only one port requesting: that port is granted.
  - Both requesting: port 0 is granted (fixed priority), unless the optional feature below is compiled in.
  - Neither requesting: no grant.
- Issue stage (edge N, where N is the ACK cycle):
  - MEM_ADDRESS, MEM_DATA_IN and MEM_MASK load the granted port's fields.
  - MEM_WR loads the granted port's WR.
  - With no grant, MEM_WR loads 0 and the other MEM_* outputs hold their values.
  - A read loads MEM_MASK=2'b00 and MEM_WR=0.
- Read return:
  - Memory samples at edge N+1; data is valid during cycle N+2.
  - Mx_RVALID is registered and high for exactly one cycle, in cycle N+2, for the port that issued the read.
  - M0_RDATA and M1_RDATA both equal MEM_DATA_OUT; each is meaningful only while its RVALID is high.
  - Writes produce no RVALID.
- Pipelining:
  - One access can be accepted every cycle; back-to-back reads give RVALID on consecutive cycles.
  - Ordering is preserved, so a write followed by a read of the same address returns the written data.
- Read pipeline: two stages, each holding {valid, port}.
- Reset mid-operation: in-flight reads are discarded, no RVALID is asserted on the cycle after reset deasserts, and MEM_WR=0 on the cycle after reset is sampled.
- Requests held through reset are granted normally from the first cycle after RST deasserts.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the port not granted most recently wins. The pointer updates on every grant.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins, and the pointer logic is absent.

Decomposition:
- Shared package holds:
  - PORT_CPU=0 and PORT_DMA=1.
  - MEM_RD_LATENCY=2.
  - Mask encodings MASK_NONE=2'b00, MASK_LO=2'b01, MASK_HI=2'b10, MASK_WORD=2'b11.
- One sub-module: mem_arb_rd_pipe, the {valid, port} shift register with synchronous clear that drives both RVALIDs.

Test Plan:
1. Port 0 writes 16'hBEEF to address 0x0010 with mask 2'b11, then reads 0x0010 -> M0_ACK high in both request cycles; M0_RVALID high two cycles after the read ACK with M0_RDATA=16'hBEEF; M1_RVALID stays 0.
2. Both ports request reads, port 0 at 0x0001 and port 1 at 0x0002, with REQs held -> fixed priority: port 0 is granted first, port 1 on the next cycle. RVALIDs arrive on consecutive cycles, in the same order.
3. Same as test 2 with MEM_ARB_ROUND_ROBIN_EN and both ports re-requesting continuously -> grants alternate 0,1,0,1 and no port waits more than one cycle.
4. Port 1 byte write 16'h12xx with mask 2'b10 to 0x0003, which holds 16'h0055 -> a read of 0x0003 returns 16'h1255.
5. Issue a read, then assert RST in the following cycle -> no RVALID is ever produced for that read; MEM_WR=0 and all outputs are at reset values one cycle after RST is sampled.
6. Four back-to-back port 0 reads of 0x0000–0x0003 -> four consecutive single-cycle RVALID pulses, with data in address order.
